// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipeline stage buffer: state encoding,
// reg_write_tgt one-hot bit positions and small helpers.
package pipe_stage_buf_pkg;

    // Buffer occupancy states: head only, head plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // reg_write_tgt one-hot bit indices (6-bit field).
    localparam int unsigned TGT_RD   = 0;  // write rd
    localparam int unsigned TGT_RT   = 4;  // write rt
    localparam int unsigned TGT_RA   = 5;  // write link register r31
    localparam int unsigned TGT_W    = 6;
    localparam logic [4:0]  LINK_REG = 5'd31;

    // Map a buffer state onto its entry count; unknown encodings report 0.
    function automatic logic [1:0] state_to_occ(input buf_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_waddr_decode.sv
// Destination-register decode from instruction and one-hot reg_write_tgt.
// Purely combinational so the decode stage can share it.
module pipe_waddr_decode
    import pipe_stage_buf_pkg::*;
(
    input  logic [31:0]    inst_i,
    input  logic [TGT_W-1:0] tgt_i,
    output logic [4:0]     waddr_o
);

    logic [4:0] rd_s;
    logic [4:0] rt_s;
    logic       unused_s;

    assign rd_s     = inst_i[15:11];
    assign rt_s     = inst_i[20:16];
    // Remaining instruction and target bits do not select a register.
    assign unused_s = ^{inst_i[31:21], inst_i[10:0], tgt_i[3:1]};

    // OR together every selected source; a malformed multi-hot target
    // merges sources rather than prioritising one.
    always_comb begin
        waddr_o = 5'd0;
        if (tgt_i[TGT_RD]) begin
            waddr_o = waddr_o | rd_s;
        end else begin
            waddr_o = waddr_o;
        end
        if (tgt_i[TGT_RT]) begin
            waddr_o = waddr_o | rt_s;
        end else begin
            waddr_o = waddr_o;
        end
        if (tgt_i[TGT_RA]) begin
            waddr_o = waddr_o | LINK_REG;
        end else begin
            waddr_o = waddr_o;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages. in_ready depends only on
// registered state, so there is no combinational path from out_ready back
// upstream. The head entry also exposes its GPR write target for forwarding.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned WIDTH    = 220,
    parameter int unsigned INST_LSB = 188,
    parameter int unsigned TGT_LSB  = 71,
    parameter int unsigned WEN_BIT  = 93
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             fwd_valid,
    output logic [4:0]       fwd_waddr,
    output logic [1:0]       occupancy
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q,  head_d;
    logic [WIDTH-1:0] skid_q,  skid_d;

    logic             in_fire_s;
    logic             out_fire_s;
    logic [4:0]       waddr_s;

    assign in_ready   = (state_q != ST_FULL) & ~rst;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = head_q;
    assign occupancy  = state_to_occ(state_q);
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    pipe_waddr_decode u_waddr_decode (
        .inst_i  (head_q[INST_LSB +: 32]),
        .tgt_i   (head_q[TGT_LSB +: TGT_W]),
        .waddr_o (waddr_s)
    );

    assign fwd_waddr = out_valid ? waddr_s : 5'd0;
    assign fwd_valid = out_valid & head_q[WEN_BIT] & (waddr_s != 5'd0);

    // Next-state and data-movement logic; flush overrides any acceptance.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_d = ST_ONE;
                    head_d  = in_data;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    state_d = ST_ONE;
                    head_d  = in_data;
                end else if (in_fire_s) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (out_fire_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_fire_s) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_d;
        end
    end

    // State and payload registers with synchronous reset clearing both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= {WIDTH{1'b0}};
            skid_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule
